// File: rtl/pad_window_gen.sv
// Position-aware zero-padding stage for KxK windows scanned over an IMG_H x IMG_W raster.
// Latency: 1 cycle from accept to o_valid; sustains one window per cycle.
// Backpressure: o_ready drops while o_valid && !i_ready; all outputs hold until consumed.
module pad_window_gen #(
    parameter int DATA_W = 10,
    parameter int K      = 3,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    localparam int TAPS  = K * K,
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_pad_en,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TAPS*DATA_W-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [TAPS*DATA_W-1:0] o_data,
    output logic [TAPS-1:0]        o_sel,
    output logic [RW-1:0]          o_row,
    output logic [CW-1:0]          o_col,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int PAD  = K / 2;
    localparam int MAXD = (IMG_H > IMG_W) ? ((IMG_H > K) ? IMG_H : K)
                                          : ((IMG_W > K) ? IMG_W : K);
    // Signed width covers row+r-PAD for the largest dimension plus a sign bit.
    localparam int SW   = $clog2(MAXD) + 2;

    localparam logic signed [SW-1:0] PAD_S = SW'(PAD);
    localparam logic signed [SW-1:0] H_MAX = SW'(IMG_H - 1);
    localparam logic signed [SW-1:0] W_MAX = SW'(IMG_W - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      row_q;
    logic [CW-1:0]      col_q;
    logic               pad_en_q;
    logic [TAPS-1:0]    sel;
    logic signed [SW-1:0] rr, cc;
    logic               accept;
    logic               last_pos;
    logic               consume;

    assign o_ready  = (state == ST_RUN) && (!o_valid || i_ready);
    assign accept   = i_valid && o_ready;
    assign consume  = o_valid && i_ready;
    assign last_pos = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign o_busy   = (state != ST_IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: start a scan, drain after the final accept, idle once it is consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start)            state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_pos) state_nxt = ST_DRAIN;
            ST_DRAIN: if (consume)            state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // Keep mask from the current position: a tap survives only if it lands inside the image.
    always_comb begin
        sel = '1;
        rr  = '0;
        cc  = '0;
        if (pad_en_q) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    rr = SW'(row_q) + SW'(r) - PAD_S;
                    cc = SW'(col_q) + SW'(c) - PAD_S;
                    sel[r*K+c] = !rr[SW-1] && (rr <= H_MAX) && !cc[SW-1] && (cc <= W_MAX);
                end
            end
        end
    end

    // Raster counters and pad-enable latch; counters only move on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            pad_en_q <= 1'b1;
        end else if (state == ST_IDLE) begin
            if (i_start) begin
                pad_en_q <= i_pad_en;
                row_q    <= '0;
                col_q    <= '0;
            end
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Output register: load on accept, drop valid when consumed without a refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            o_row   <= '0;
            o_col   <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            for (int t = 0; t < TAPS; t++) begin
                o_data[t*DATA_W +: DATA_W] <= sel[t] ? i_data[t*DATA_W +: DATA_W] : '0;
            end
            o_sel  <= sel;
            o_row  <= row_q;
            o_col  <= col_q;
            o_last <= last_pos;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Done pulse follows the edge on which the final window leaves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_done <= 1'b0;
        else          o_done <= (state == ST_DRAIN) && consume;
    end

endmodule

// File: tb/tb_pad_window_gen.sv
// Scoreboard bench: a 3x3/4x4 instance for the scan, backpressure and reset cases,
// plus a 5x5/3x3 instance for the wide-kernel mask.
// Expected windows are queued on accept and compared while they sit on the output.
module tb_pad_window_gen;

    logic        clk;
    logic        rst_n;
    logic        start, pad_en, iv, ir;
    logic [89:0] idat;
    logic        ordy, ov, olast, obusy, odone;
    logic [89:0] odat;
    logic [8:0]  osel;
    logic [1:0]  orow, ocol;

    logic         k5_start, k5_pad, k5_iv, k5_ir;
    logic [249:0] k5_idat, k5_odat;
    logic         k5_ordy, k5_ov, k5_last, k5_busy, k5_done;
    logic [24:0]  k5_sel;
    logic [1:0]   k5_row, k5_col;

    typedef struct {
        logic [89:0] d;
        logic [8:0]  s;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   n_cmp, n_err;
    int   n_out, n_last, done_cnt;
    bit   t1_chk;

    pad_window_gen #(.DATA_W(10), .K(3), .IMG_W(4), .IMG_H(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pad_en(pad_en),
        .i_valid(iv), .o_ready(ordy), .i_data(idat), .o_valid(ov), .i_ready(ir),
        .o_data(odat), .o_sel(osel), .o_row(orow), .o_col(ocol), .o_last(olast),
        .o_busy(obusy), .o_done(odone)
    );

    pad_window_gen #(.DATA_W(10), .K(5), .IMG_W(3), .IMG_H(3)) u_dut_k5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(k5_start), .i_pad_en(k5_pad),
        .i_valid(k5_iv), .o_ready(k5_ordy), .i_data(k5_idat), .o_valid(k5_ov), .i_ready(k5_ir),
        .o_data(k5_odat), .o_sel(k5_sel), .o_row(k5_row), .o_col(k5_col), .o_last(k5_last),
        .o_busy(k5_busy), .o_done(k5_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && odone) done_cnt++;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] model_sel(input int row, input int col, input int k,
                                              input int h, input int w, input bit pe);
        logic [24:0] m;
        int pr, pc;
        m = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                pr = row + r - k / 2;
                pc = col + c - k / 2;
                m[r*k+c] = !pe || (pr >= 0 && pr < h && pc >= 0 && pc < w);
            end
        end
        return m;
    endfunction

    // Drive one frame with valid/ready probabilities in percent; optionally stop after abort_after accepts.
    task automatic run_frame(input int pv, input int pr, input bit pe, input bit idx_data,
                             input bit noise, input int abort_after);
        int   sent, cyc;
        bit   acc;
        exp_t e;
        logic [24:0] m;
        @(negedge clk);
        pad_en = pe;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pad_en = !pe;
        sent   = 0;
        iv     = 1'b0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (!iv && sent < 16 && $urandom_range(99) < pv) begin
                iv = 1'b1;
                for (int t = 0; t < 9; t++)
                    idat[t*10 +: 10] = idx_data ? 10'(t) : 10'($urandom);
            end
            ir    = ($urandom_range(99) < pr);
            start = noise && obusy && $urandom_range(1) == 1;
            #1;
            if (ov) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q[0];
                    chk("out_data", odat, e.d);
                    chk("out_sel",  osel, e.s);
                    chk("out_pos",  {orow, ocol}, {e.r, e.c});
                    chk("out_last", olast, e.l);
                    if (t1_chk && orow == 2'd0 && ocol == 2'd0) chk("t1_sel_00", osel, 9'b110110000);
                    if (t1_chk && orow == 2'd1 && ocol == 2'd1) chk("t1_sel_11", osel, 9'h1FF);
                    if (t1_chk && orow == 2'd3 && ocol == 2'd3) chk("t1_sel_33", osel, 9'b000011011);
                    if (ir) begin
                        void'(q.pop_front());
                        n_out++;
                        if (olast) n_last++;
                    end
                end
            end
            acc = iv && ordy;
            if (acc) begin
                m   = model_sel(sent / 4, sent % 4, 3, 4, 4, pe);
                e.s = m[8:0];
                for (int t = 0; t < 9; t++) e.d[t*10 +: 10] = m[t] ? idat[t*10 +: 10] : 10'd0;
                e.r = 2'(sent / 4);
                e.c = 2'(sent % 4);
                e.l = (sent == 15);
                q.push_back(e);
                sent++;
            end
            @(negedge clk);
            if (acc) iv = 1'b0;
            if (abort_after > 0 && sent == abort_after) break;
            if (sent == 16 && q.size() == 0 && !obusy) break;
        end
        if (cyc >= 2000) chk("frame_timeout", 0, 1);
        if (abort_after == 0) chk("frame_windows", sent, 16);
        start = 1'b0;
        ir    = 1'b1;
        if (abort_after == 0) iv = 1'b0;
    endtask

    task automatic full_frame(input string tag, input int pv, input int pr, input bit pe,
                              input bit idx_data, input bit noise);
        int d0, o0, l0;
        d0 = done_cnt; o0 = n_out; l0 = n_last;
        run_frame(pv, pr, pe, idx_data, noise, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done"},  done_cnt - d0, 1);
        chk({tag, "_count"}, n_out - o0, 16);
        chk({tag, "_lasts"}, n_last - l0, 1);
        chk({tag, "_idle"},  obusy, 0);
    endtask

    initial begin
        int got5, sent5;
        logic [24:0] m5;
        n_cmp = 0; n_err = 0; n_out = 0; n_last = 0; done_cnt = 0; t1_chk = 0;
        rst_n = 1'b0; start = 0; pad_en = 1; iv = 0; ir = 1; idat = '0;
        k5_start = 0; k5_pad = 1; k5_iv = 0; k5_ir = 1; k5_idat = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_busy",  obusy, 0);
        chk("rst_done",  odone, 0);
        chk("rst_last",  olast, 0);
        chk("rst_data",  odat, 0);
        chk("rst_sel",   osel, 0);
        chk("rst_pos",   {orow, ocol}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", ordy, 0);

        t1_chk = 1;
        full_frame("t1", 100, 100, 1'b1, 1'b1, 1'b0);
        t1_chk = 0;
        full_frame("t2", 100, 100, 1'b0, 1'b0, 1'b0);
        full_frame("t3a", 50, 30, 1'b1, 1'b0, 1'b0);
        full_frame("t3b", 50, 30, 1'b0, 1'b0, 1'b0);

        run_frame(60, 50, 1'b1, 1'b0, 1'b0, 7);
        rst_n = 1'b0;
        #1;
        chk("t4_valid", ov, 0);
        chk("t4_busy",  obusy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        iv = 1'b0;
        q.delete();
        full_frame("t4_restart", 70, 70, 1'b1, 1'b0, 1'b0);

        full_frame("t5", 60, 50, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_stay_idle", obusy, 0);

        @(negedge clk);
        k5_start = 1'b1;
        @(negedge clk);
        k5_start = 1'b0;
        k5_iv = 1'b1;
        got5 = 0; sent5 = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int t = 0; t < 25; t++) k5_idat[t*10 +: 10] = 10'($urandom);
            #1;
            if (k5_ov) begin
                m5 = model_sel(int'(k5_row), int'(k5_col), 5, 3, 3, 1'b1);
                chk("k5_sel", k5_sel, m5);
                if (k5_row == 2'd1 && k5_col == 2'd1) chk("k5_sel_11", k5_sel, 25'h0073_9C0);
                got5++;
            end
            if (k5_iv && k5_ordy) sent5++;
            @(negedge clk);
            if (sent5 == 9) k5_iv = 1'b0;
            if (got5 == 9 && !k5_busy) break;
        end
        chk("k5_count", got5, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
